// File: rtl/shared_bram_loader.sv
// Host-side sequencer for the pipelined_processor shared BRAM port: turns word
// write/read commands into BRAM cycles, then runs the processor for a set number of clocks.
module shared_bram_loader #(
    parameter int WIDTH   = 32,
    parameter int SIZE    = 256,
    parameter int NUM_COL = 4,
    parameter int CYC_W   = 32,
    localparam int LOGSIZE = $clog2(SIZE),
    localparam int AW      = LOGSIZE + 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic               cmd_write,
    input  logic [AW-1:0]      cmd_addr,
    input  logic [WIDTH-1:0]   cmd_wdata,
    input  logic [NUM_COL-1:0] cmd_byte_en,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [WIDTH-1:0]   rsp_rdata,
    input  logic               start_run,
    input  logic [CYC_W-1:0]   run_cycles,
    output logic               cpu_reset,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   bram_din,
    output logic [AW-1:0]      shared_bram_addr,
    output logic [NUM_COL-1:0] bram_wr_en,
    input  logic [WIDTH-1:0]   bram_dout,
    output logic [2:0]         state_dbg
);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_RD_ADDR = 3'd1;
    localparam logic [2:0] ST_RD_DATA = 3'd2;
    localparam logic [2:0] ST_RESP    = 3'd3;
    localparam logic [2:0] ST_RUN     = 3'd4;

    logic [2:0]       state;
    logic [CYC_W-1:0] counter;
    logic [AW-1:0]    word_addr;
    logic             cmd_fire;
    logic             unused_addr_lsbs;

    // Handshakes: a transfer happens on a clock edge where valid && ready are both
    // high; valid never depends on ready, and a raised rsp_valid holds its data until taken.
    assign cmd_ready = reset && (state == ST_IDLE) && !start_run;
    assign cmd_fire  = cmd_valid && cmd_ready;
    assign busy      = (state != ST_IDLE);
    assign state_dbg = state;

    // Byte address is word aligned on the way out; the low two bits are dropped.
    assign word_addr        = {cmd_addr[AW-1:2], 2'b00};
    assign unused_addr_lsbs = ^cmd_addr[1:0];

    always_ff @(posedge clk) begin
        if (!reset) begin
            state            <= ST_IDLE;
            counter          <= '0;
            cpu_reset        <= 1'b1;
            done             <= 1'b0;
            rsp_valid        <= 1'b0;
            rsp_rdata        <= '0;
            bram_din         <= '0;
            shared_bram_addr <= '0;
            bram_wr_en       <= '0;
        end else begin
            done       <= 1'b0;
            bram_wr_en <= '0;
            case (state)
                ST_IDLE: begin
                    if (start_run) begin
                        if (run_cycles == '0) begin
                            done <= 1'b1;
                        end else begin
                            counter          <= run_cycles;
                            state            <= ST_RUN;
                            cpu_reset        <= 1'b0;
                            shared_bram_addr <= '0;
                        end
                    end else if (cmd_fire) begin
                        shared_bram_addr <= word_addr;
                        if (cmd_write) begin
                            bram_din   <= cmd_wdata;
                            bram_wr_en <= cmd_byte_en;
                        end else begin
                            state <= ST_RD_ADDR;
                        end
                    end
                end
                ST_RD_ADDR: state <= ST_RD_DATA;
                ST_RD_DATA: begin
                    // BRAM has one cycle of read latency, so dout belongs to the address driven last cycle.
                    rsp_rdata <= bram_dout;
                    rsp_valid <= 1'b1;
                    state     <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    counter <= counter - CYC_W'(1);
                    if (counter == CYC_W'(1)) begin
                        state     <= ST_IDLE;
                        cpu_reset <= 1'b1;
                        done      <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_shared_bram_loader.sv
// Directed bench for shared_bram_loader with a behavioural 1-cycle-latency BRAM
// standing in for the processor's shared port.
module tb_shared_bram_loader;

    localparam int WIDTH   = 32;
    localparam int SIZE    = 256;
    localparam int NUM_COL = 4;
    localparam int CYC_W   = 32;
    localparam int AW      = $clog2(SIZE) + 3;

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic               cmd_valid = 1'b0;
    logic               cmd_ready;
    logic               cmd_write = 1'b0;
    logic [AW-1:0]      cmd_addr = '0;
    logic [WIDTH-1:0]   cmd_wdata = '0;
    logic [NUM_COL-1:0] cmd_byte_en = '0;
    logic               rsp_valid;
    logic               rsp_ready = 1'b0;
    logic [WIDTH-1:0]   rsp_rdata;
    logic               start_run = 1'b0;
    logic [CYC_W-1:0]   run_cycles = '0;
    logic               cpu_reset;
    logic               busy;
    logic               done;
    logic [WIDTH-1:0]   bram_din;
    logic [AW-1:0]      shared_bram_addr;
    logic [NUM_COL-1:0] bram_wr_en;
    logic [WIDTH-1:0]   bram_dout = '0;
    logic [2:0]         state_dbg;

    int total = 0;
    int bad   = 0;

    logic [WIDTH-1:0] mem [0:(1 << (AW-2))-1];

    shared_bram_loader #(
        .WIDTH(WIDTH), .SIZE(SIZE), .NUM_COL(NUM_COL), .CYC_W(CYC_W)
    ) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_byte_en(cmd_byte_en),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .start_run(start_run), .run_cycles(run_cycles),
        .cpu_reset(cpu_reset), .busy(busy), .done(done),
        .bram_din(bram_din), .shared_bram_addr(shared_bram_addr),
        .bram_wr_en(bram_wr_en), .bram_dout(bram_dout), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    // Processor-side BRAM: byte-lane writes, registered read.
    always @(posedge clk) begin
        for (int c = 0; c < NUM_COL; c++)
            if (bram_wr_en[c]) mem[shared_bram_addr[AW-1:2]][c*8 +: 8] <= bram_din[c*8 +: 8];
        bram_dout <= mem[shared_bram_addr[AW-1:2]];
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) begin
            tick();
            total++; if (cpu_reset !== 1'b1) begin bad++; $display("FAIL rst_cpu_reset got=%b exp=1", cpu_reset); end
            total++; if (bram_wr_en !== 4'h0) begin bad++; $display("FAIL rst_wr_en got=%h exp=0", bram_wr_en); end
            total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL rst_rsp_valid got=%b exp=0", rsp_valid); end
            total++; if (cmd_ready !== 1'b0) begin bad++; $display("FAIL rst_cmd_ready got=%b exp=0", cmd_ready); end
            total++; if (shared_bram_addr !== '0) begin bad++; $display("FAIL rst_addr got=%h exp=0", shared_bram_addr); end
            total++; if (done !== 1'b0) begin bad++; $display("FAIL rst_done got=%b exp=0", done); end
        end
        reset = 1'b1;
        tick();
        total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL rst_release_ready got=%b exp=1", cmd_ready); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_release_busy got=%b exp=0", busy); end
        total++; if (cpu_reset !== 1'b1) begin bad++; $display("FAIL rst_release_cpu_reset got=%b exp=1", cpu_reset); end
    endtask

    task automatic test_back_to_back();
        logic [AW-1:0]    addrs [3];
        logic [WIDTH-1:0] datas [3];
        addrs = '{11'h000, 11'h004, 11'h008};
        datas = '{32'hA, 32'hB, 32'hC};
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_byte_en = 4'hF;
        for (int i = 0; i < 3; i++) begin
            cmd_addr = addrs[i]; cmd_wdata = datas[i];
            #1;
            total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready[%0d] got=%b exp=1", i, cmd_ready); end
            tick();
            total++; if (bram_wr_en !== 4'hF) begin bad++; $display("FAIL b2b_wr_en[%0d] got=%h exp=f", i, bram_wr_en); end
            total++; if (shared_bram_addr !== addrs[i]) begin bad++; $display("FAIL b2b_addr[%0d] got=%h exp=%h", i, shared_bram_addr, addrs[i]); end
            total++; if (bram_din !== datas[i]) begin bad++; $display("FAIL b2b_din[%0d] got=%h exp=%h", i, bram_din, datas[i]); end
            total++; if (busy !== 1'b0) begin bad++; $display("FAIL b2b_busy[%0d] got=%b exp=0", i, busy); end
        end
        cmd_valid = 1'b0;
        tick();
        total++; if (bram_wr_en !== 4'h0) begin bad++; $display("FAIL b2b_wr_en_drop got=%h exp=0", bram_wr_en); end
    endtask

    task automatic test_read();
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 11'h404;
        cmd_wdata = 32'hDEADBEEF; cmd_byte_en = 4'hF;
        tick();
        total++; if (shared_bram_addr !== 11'h404) begin bad++; $display("FAIL rd_wr_addr got=%h exp=404", shared_bram_addr); end
        total++; if (bram_wr_en !== 4'hF) begin bad++; $display("FAIL rd_wr_en got=%h exp=f", bram_wr_en); end
        cmd_write = 1'b0; cmd_addr = 11'h405; rsp_ready = 1'b0;
        tick();
        cmd_valid = 1'b0;
        total++; if (shared_bram_addr !== 11'h404) begin bad++; $display("FAIL rd_addr_aligned got=%h exp=404", shared_bram_addr); end
        total++; if (bram_wr_en !== 4'h0) begin bad++; $display("FAIL rd_addr_wr_en got=%h exp=0", bram_wr_en); end
        total++; if (cmd_ready !== 1'b0) begin bad++; $display("FAIL rd_addr_ready got=%b exp=0", cmd_ready); end
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL rd_addr_rsp_valid got=%b exp=0", rsp_valid); end
        tick();
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL rd_data_rsp_valid got=%b exp=0", rsp_valid); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL rd_data_busy got=%b exp=1", busy); end
        for (int i = 0; i < 4; i++) begin
            tick();
            total++; if (rsp_valid !== 1'b1) begin bad++; $display("FAIL rd_resp_valid[%0d] got=%b exp=1", i, rsp_valid); end
            total++; if (rsp_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL rd_resp_data[%0d] got=%h exp=deadbeef", i, rsp_rdata); end
            total++; if (cmd_ready !== 1'b0) begin bad++; $display("FAIL rd_resp_ready[%0d] got=%b exp=0", i, cmd_ready); end
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL rd_done_valid got=%b exp=0", rsp_valid); end
        total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL rd_done_ready got=%b exp=1", cmd_ready); end
        // Partial lane write: only lanes 0 and 2 change.
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 11'h404;
        cmd_wdata = 32'h11223344; cmd_byte_en = 4'b0101;
        tick();
        total++; if (bram_wr_en !== 4'b0101) begin bad++; $display("FAIL lane_wr_en got=%b exp=0101", bram_wr_en); end
        cmd_write = 1'b0; rsp_ready = 1'b1;
        tick();
        cmd_valid = 1'b0;
        repeat (2) tick();
        total++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hDE22BE44) begin bad++; $display("FAIL lane_read got=%b/%h exp=1/de22be44", rsp_valid, rsp_rdata); end
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic test_run();
        int cnt;
        bit ended;
        cnt = 0; ended = 1'b0;
        start_run = 1'b1; run_cycles = 10;
        tick();
        start_run = 1'b0;
        for (int i = 0; i < 30 && !ended; i++) begin
            if (cpu_reset === 1'b0) begin
                cnt++;
                total++; if (busy !== 1'b1 || done !== 1'b0) begin bad++; $display("FAIL run_busy_done[%0d] got=%b/%b exp=1/0", i, busy, done); end
                tick();
            end else begin
                ended = 1'b1;
            end
        end
        total++; if (!ended) begin bad++; $display("FAIL run_timeout got=running exp=ended"); end
        total++; if (cnt != 10) begin bad++; $display("FAIL run_length got=%0d exp=10", cnt); end
        total++; if (done !== 1'b1) begin bad++; $display("FAIL run_done_pulse got=%b exp=1", done); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL run_end_busy got=%b exp=0", busy); end
        tick();
        total++; if (done !== 1'b0) begin bad++; $display("FAIL run_done_one_cycle got=%b exp=0", done); end
    endtask

    task automatic test_collision();
        int guard;
        start_run = 1'b1; run_cycles = 5;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 11'h010;
        cmd_wdata = 32'h55; cmd_byte_en = 4'hF;
        #1;
        total++; if (cmd_ready !== 1'b0) begin bad++; $display("FAIL coll_ready got=%b exp=0", cmd_ready); end
        tick();
        start_run = 1'b0;
        total++; if (cpu_reset !== 1'b0) begin bad++; $display("FAIL coll_run_started got=%b exp=0", cpu_reset); end
        guard = 0;
        while (cpu_reset === 1'b0 && guard < 20) begin
            total++; if (bram_wr_en !== 4'h0 || cmd_ready !== 1'b0 || shared_bram_addr !== '0) begin
                bad++; $display("FAIL coll_run_port[%0d] got=wr%h rdy%b addr%h exp=wr0 rdy0 addr0", guard, bram_wr_en, cmd_ready, shared_bram_addr);
            end
            guard++;
            tick();
        end
        cmd_valid = 1'b0;
        total++; if (guard != 5) begin bad++; $display("FAIL coll_run_length got=%0d exp=5", guard); end
        start_run = 1'b1; run_cycles = 0;
        tick();
        start_run = 1'b0;
        total++; if (done !== 1'b1) begin bad++; $display("FAIL zero_done got=%b exp=1", done); end
        total++; if (cpu_reset !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL zero_no_run got=%b/%b exp=1/0", cpu_reset, busy); end
        tick();
        total++; if (done !== 1'b0 || cpu_reset !== 1'b1) begin bad++; $display("FAIL zero_after got=%b/%b exp=0/1", done, cpu_reset); end
    endtask

    task automatic test_reset_mid();
        start_run = 1'b1; run_cycles = 20;
        tick();
        start_run = 1'b0;
        repeat (3) tick();
        total++; if (cpu_reset !== 1'b0) begin bad++; $display("FAIL mid_run_active got=%b exp=0", cpu_reset); end
        reset = 1'b0;
        tick();
        total++; if (cpu_reset !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL mid_run_reset got=%b/%b/%b exp=1/0/0", cpu_reset, busy, done); end
        reset = 1'b1;
        tick();
        total++; if (state_dbg !== 3'd0 || cmd_ready !== 1'b1) begin bad++; $display("FAIL mid_run_release got=%0d/%b exp=0/1", state_dbg, cmd_ready); end
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 11'h404; rsp_ready = 1'b0;
        tick();
        cmd_valid = 1'b0;
        repeat (2) tick();
        total++; if (rsp_valid !== 1'b1) begin bad++; $display("FAIL mid_rsp_pending got=%b exp=1", rsp_valid); end
        reset = 1'b0;
        tick();
        total++; if (rsp_valid !== 1'b0 || rsp_rdata !== '0 || cpu_reset !== 1'b1) begin bad++; $display("FAIL mid_rsp_reset got=%b/%h/%b exp=0/0/1", rsp_valid, rsp_rdata, cpu_reset); end
        reset = 1'b1;
        tick();
        total++; if (busy !== 1'b0 || rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin bad++; $display("FAIL mid_rsp_release got=%b/%b/%b exp=0/0/1", busy, rsp_valid, cmd_ready); end
    endtask

    initial begin
        for (int i = 0; i < (1 << (AW-2)); i++) mem[i] = '0;
        test_reset();
        test_back_to_back();
        test_read();
        test_run();
        test_collision();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/shared_bram_loader.md
Name: shared_bram_loader

Overview:
Host-side sequencer that sits directly upstream of pipelined_processor and drives its shared BRAM load port: bram_din, shared_bram_addr, bram_wr_en and bram_dout.
- Accepts word write/read commands over a valid/ready interface and converts them into BRAM port cycles.
- Holds the processor in reset while loading, then runs it for a programmed number of cycles and signals completion.
- Lets a host load imem/dmem, execute a program and read results back without a testbench driving the port.

Parameters:
WIDTH, 32, data word width
SIZE, 256, words per memory (imem and dmem each); LOGSIZE=$clog2(SIZE)
NUM_COL, 4, byte-write lanes
CYC_W, 32, width of run-cycle counter

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset
cmd_valid  in  1  host command valid
cmd_ready  out  1  loader accepts command
cmd_write  in  1  1=write, 0=read
cmd_addr  in  LOGSIZE+3  byte address; bit LOGSIZE+2 selects dmem
cmd_wdata  in  WIDTH  write data
cmd_byte_en  in  NUM_COL  write lane enables
rsp_valid  out  1  read data valid
rsp_ready  in  1  host accepts read data
rsp_rdata  out  WIDTH  read data
start_run  in  1  pulse: release processor for run_cycles clocks
run_cycles  in  CYC_W  execution length, sampled on start_run
cpu_reset  out  1  active-high reset to pipelined_processor
busy  out  1  state != IDLE
done  out  1  one-cycle pulse at end of run
bram_din  out  WIDTH  to processor shared port
shared_bram_addr  out  LOGSIZE+3  to processor, byte address
bram_wr_en  out  NUM_COL  to processor
bram_dout  in  WIDTH  from processor, 1-cycle registered read

Behaviour:
- Reset (reset==0 at posedge):
  - state=IDLE, cpu_reset=1, bram_wr_en=0, shared_bram_addr=0, bram_din=0.
  - rsp_valid=0, rsp_rdata=0, done=0, counter=0.
  - cmd_ready=0 while reset is low.
- States:
  - IDLE: cmd_ready = !start_run. cpu_reset=1.
  - RD_ADDR, RD_DATA, RESP: read path.
  - RUN: processor executing.
- Write, handshake at cycle T: in cycle T+1 drive shared_bram_addr = {cmd_addr[LOGSIZE+2:2],2'b00}, bram_din=cmd_wdata, bram_wr_en=cmd_byte_en. bram_wr_en returns to 0 at T+2 unless another write is accepted at T+1.
  - Back-to-back writes are accepted every cycle; state stays IDLE.
- Read, handshake at T:
  - T+1 (RD_ADDR): address driven, bram_wr_en=0, cmd_ready=0.
  - T+2 (RD_DATA): bram_dout valid, captured into rsp_rdata at end of cycle.
  - T+3 onward (RESP): rsp_valid=1, rsp_rdata stable, held until rsp_valid&&rsp_ready; then IDLE, with cmd_ready=1 the next cycle.
- Address bits [1:0] are ignored (forced 0). The full LOGSIZE+3 range is legal; no wrap or error.
- start_run is honoured only in IDLE and has priority over a simultaneous cmd_valid (cmd_ready=0 that cycle, command not consumed). In any other state start_run is ignored.
  - run_cycles==0: no RUN; done pulses the next cycle; cpu_reset stays 1.
  - Otherwise the counter loads run_cycles, state=RUN, cpu_reset=0 for exactly run_cycles clocks.
  - Counter decrements each RUN cycle. At counter==1: next state IDLE, cpu_reset=1, done=1 for one cycle.
- During RUN: cmd_ready=0, bram_wr_en=0, shared_bram_addr held at 0.
- reset low mid-read or mid-run: immediate return to reset values. A pending response is discarded and cpu_reset reasserts the same edge.
- All BRAM-side and control outputs are registered; cmd_ready is combinational from state and start_run.

Test Plan:
1. Reset low 3 cycles, then high -> cpu_reset=1, bram_wr_en=0, rsp_valid=0, cmd_ready=1 one cycle after release.
2. Back-to-back writes addr 0,4,8 data 0xA,0xB,0xC, byte_en 4'hF -> bram_wr_en=4'hF three consecutive cycles, addresses 0,4,8 one cycle after each handshake.
3. Write 0xDEADBEEF to addr 0x404 (dmem), then read 0x405 -> shared_bram_addr=0x404; rsp_valid rises 3 cycles after handshake with rsp_rdata=0xDEADBEEF. Hold rsp_ready=0 for 4 cycles -> data stable, cmd_ready=0.
4. start_run with run_cycles=10 -> cpu_reset=0 for exactly 10 cycles, done pulse coincides with cpu_reset returning 1, busy high throughout.
5. start_run and cmd_valid (write) in the same cycle -> run starts, write not accepted (no bram_wr_en). cmd_valid during RUN -> cmd_ready=0. run_cycles=0 -> done next cycle, cpu_reset never 0.
6. reset low at RUN cycle 4 and again while RESP pending -> cpu_reset=1 and rsp_valid=0 after that edge; state IDLE when reset releases.
